multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit that sequences the existing CPU datapath (PC, register file, ALU, data RAM, write-back selector) over several clock cycles per instruction instead of one. Sits between the instruction register and the datapath control inputs; replaces the single-cycle combinational decoder when the core is built in multi-cycle mode. It produces the same control-signal set with the same polarities, plus PC and IR write enables, a memory handshake stall, and an illegal-opcode trap.

## Interface
- No parameters; opcode, funct and ALUop encodings are fixed constants in the shared package.
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; forces state FETCH and all enables low
- instr  in  32  instruction word from the IR/instruction ROM; sampled in DECODE
- zero  in  1  ALU zero flag; sampled in EXEC for beq
- mem_ready  in  1  data RAM completion; MEM state waits for it
- pcWrite  out  1  PC update enable (PC+4, branch or jump target)
- irWrite  out  1  latch fetched instruction
- regDst  out  1  1 selects rt (instr[20:16]), 0 selects rd (instr[15:11])
- link  out  1  forces write address to 31 (jal)
- ALUSrc  out  1  1 selects RtData, 0 selects sign-extended immediate
- memToReg, ALUToReg  out  1 each  write-back select: 1/1 memory, 0/1 ALU result, 0/0 pAddr (link)
- regWrite, memRead, memWrite, jump, branch  out  1 each  active-high enables
- ALUop  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
- state_o  out  3  current state, for debug
- done  out  1  one-cycle pulse in an instruction's final cycle
- trap  out  1  high while in ILLEGAL

## Operation
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), ILLEGAL(7).
- FETCH: irWrite=1, pcWrite=1 (PC<=PC+4). Go to DECODE.
- DECODE: latch opcode instr[31:26] and funct instr[5:0] into internal registers; all other outputs 0. Supported opcodes: 000000 R-type (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100, addi 001000, ori 001101, j 000010, jal 000011. Any other opcode, or an R-type with any other funct, goes to ILLEGAL; otherwise to EXEC.
- EXEC: ALUop from the latched op/funct. lw/sw/addi use add; ori uses or; beq uses sub; ALUSrc=0 for immediates, 1 for R-type/beq.
  - beq: branch=1; pcWrite=zero; done=1; next FETCH.
  - j: jump=1, pcWrite=1, done=1; next FETCH.
  - jal: jump=1, pcWrite=1, regWrite=1, link=1, ALUToReg=0, memToReg=0, done=1; next FETCH. Link value is pAddr (already PC+4).
  - lw/sw: next MEM. R-type/addi/ori: next WB.
- MEM: ALUSrc=0, ALUop=add held. lw: memRead=1; sw: memWrite=1. Stay while mem_ready=0. On mem_ready=1: sw sets done=1 and goes to FETCH; lw goes to WB.
- WB: regWrite=1. R-type: regDst=0, ALUToReg=1, memToReg=0. addi/ori: regDst=1, ALUToReg=1, memToReg=0. lw: regDst=1, ALUToReg=1, memToReg=1. done=1; next FETCH.
- ILLEGAL: trap=1, every enable 0; held until reset.
- Outputs are a pure function of the state and latched op/funct registers (Moore); no output depends combinationally on instr, and zero/mem_ready affect only pcWrite, done and the next state.

## Timing
- Reset cycle and the cycle after reset release: reset forces state FETCH; while reset=1 every output is 0, state_o=0, trap=0. The first FETCH with outputs active is the first cycle with reset=0.
- Latency with mem_ready already high: beq/j/jal 3 cycles; R-type/addi/ori/sw 4; lw 5. Each cycle mem_ready stays low adds 1 cycle.
- memRead/memWrite stay asserted and constant for the whole MEM wait; mem_ready is ignored in every other state.
- reset=1 in any state, including a MEM wait or ILLEGAL, returns the block to FETCH on the next edge with no write enable asserted in that cycle.
- A taken beq and PC+4 in FETCH never coincide; exactly one pcWrite per FETCH plus at most one per EXEC.

## Structure
- Shared package mips_pkg: state enum, opcode/funct constants, ALUop constants. The single-cycle decoder imports the same package.
- One sub-module, ctrl_decode: combinational op/funct -> {class, ALUop, legal}. The FSM and output logic stay in multicycle_ctrl.

## Test plan
- Reset held 3 cycles, then released -> all outputs 0 during reset; the first released cycle has state_o=0, irWrite=1, pcWrite=1.
- add $3,$1,$2 (0x00221820) -> states 0,1,2,4; in WB regWrite=1, regDst=0, ALUToReg=1, memToReg=0; done only in cycle 4.
- lw 0x8C220004 with mem_ready low for 2 cycles -> memRead=1 for 3 cycles in MEM, then WB with memToReg=1, ALUToReg=1, regDst=1; total 7 cycles.
- beq 0x10220003 with zero=1, then zero=0 -> EXEC pcWrite=1 / pcWrite=0; branch=1, ALUop=0110 in both; 3 cycles each.
- jal 0x0C000010 -> EXEC: jump=1, pcWrite=1, regWrite=1, link=1, ALUToReg=0, memToReg=0.
- Opcode 0x3F, then reset asserted while in ILLEGAL -> trap=1 and no enables while held; after reset, normal FETCH resumes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcodes, functs,
// ALU operation codes and the instruction classes used by the control unit.
package mips_pkg;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_ILLEGAL = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ADDI,
    CLS_ORI,
    CLS_J,
    CLS_JAL
  } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier: instruction class, ALU operation
// and a legality flag for anything the control unit cannot sequence.
module ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output op_class_t  cls,
  output logic [3:0] aluop,
  output logic       legal
);

  always_comb begin
    cls   = CLS_NONE;
    aluop = ALU_ADD;
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        cls = CLS_R;
        case (funct)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: begin
            cls   = CLS_NONE;
            legal = 1'b0;
          end
        endcase
      end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  begin
        cls   = CLS_BEQ;
        aluop = ALU_SUB;
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_ORI:  begin
        cls   = CLS_ORI;
        aluop = ALU_OR;
      end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of the datapath
// with Moore-style outputs driven from the state and the latched op/funct.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        regDst,
  output logic        link,
  output logic        ALUSrc,
  output logic        memToReg,
  output logic        ALUToReg,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        jump,
  output logic        branch,
  output logic [3:0]  ALUop,
  output logic [2:0]  state_o,
  output logic        done,
  output logic        trap
);

  logic [2:0] state_reg, state_next;
  logic [5:0] op_reg, funct_reg;
  logic [5:0] dec_op, dec_funct;
  op_class_t  cls;
  logic [3:0] dec_aluop;
  logic       legal;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  // The decoder sees the live instruction only while DECODE chooses the next
  // state; every later state works from the latched copy.
  assign dec_op    = (state_reg == S_DECODE) ? instr[31:26] : op_reg;
  assign dec_funct = (state_reg == S_DECODE) ? instr[5:0]   : funct_reg;

  ctrl_decode u_decode (
    .op    (dec_op),
    .funct (dec_funct),
    .cls   (cls),
    .aluop (dec_aluop),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      op_reg    <= 6'd0;
      funct_reg <= 6'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        op_reg    <= instr[31:26];
        funct_reg <= instr[5:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_ILLEGAL;
      S_EXEC: begin
        case (cls)
          CLS_BEQ, CLS_J, CLS_JAL: state_next = S_FETCH;
          CLS_LW, CLS_SW:          state_next = S_MEM;
          default:                 state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_next = (cls == CLS_LW) ? S_WB : S_FETCH;
      end
      S_WB:      state_next = S_FETCH;
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    regDst   = 1'b0;
    link     = 1'b0;
    ALUSrc   = 1'b0;
    memToReg = 1'b0;
    ALUToReg = 1'b0;
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    ALUop    = 4'b0000;
    done     = 1'b0;
    trap     = 1'b0;
    state_o  = 3'd0;
    // Reset blanks every output in the same cycle, whatever state is held.
    if (!reset) begin
      state_o = state_reg;
      case (state_reg)
        S_FETCH: begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
        end
        S_EXEC: begin
          ALUop  = dec_aluop;
          ALUSrc = (cls == CLS_R) || (cls == CLS_BEQ);
          case (cls)
            CLS_BEQ: begin
              branch  = 1'b1;
              pcWrite = zero;
              done    = 1'b1;
            end
            CLS_J: begin
              jump    = 1'b1;
              pcWrite = 1'b1;
              done    = 1'b1;
            end
            CLS_JAL: begin
              jump     = 1'b1;
              pcWrite  = 1'b1;
              regWrite = 1'b1;
              link     = 1'b1;
              done     = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ALUop    = ALU_ADD;
          memRead  = (cls == CLS_LW);
          memWrite = (cls == CLS_SW);
          done     = (cls == CLS_SW) && mem_ready;
        end
        S_WB: begin
          // ALU controls stay at their EXEC values so the result is stable.
          ALUop    = dec_aluop;
          ALUSrc   = (cls == CLS_R);
          regWrite = 1'b1;
          regDst   = (cls != CLS_R);
          ALUToReg = 1'b1;
          memToReg = (cls == CLS_LW);
          done     = 1'b1;
        end
        S_ILLEGAL: trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle comparison of the packed
// control outputs against hand-computed expected vectors.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pcWrite, irWrite, regDst, link, ALUSrc, memToReg, ALUToReg;
  logic        regWrite, memRead, memWrite, jump, branch, done, trap;
  logic [3:0]  ALUop;
  logic [2:0]  state_o;
  logic [20:0] vec;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .irWrite(irWrite), .regDst(regDst), .link(link),
    .ALUSrc(ALUSrc), .memToReg(memToReg), .ALUToReg(ALUToReg),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .jump(jump), .branch(branch), .ALUop(ALUop), .state_o(state_o),
    .done(done), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign vec = {state_o, done, trap, pcWrite, irWrite, regDst, link, ALUSrc,
                memToReg, ALUToReg, regWrite, memRead, memWrite, jump, branch, ALUop};

  localparam logic [20:0] B_DONE = 21'h1 << 17;
  localparam logic [20:0] B_TRAP = 21'h1 << 16;
  localparam logic [20:0] B_PCW  = 21'h1 << 15;
  localparam logic [20:0] B_IRW  = 21'h1 << 14;
  localparam logic [20:0] B_RDST = 21'h1 << 13;
  localparam logic [20:0] B_LINK = 21'h1 << 12;
  localparam logic [20:0] B_SRC  = 21'h1 << 11;
  localparam logic [20:0] B_M2R  = 21'h1 << 10;
  localparam logic [20:0] B_A2R  = 21'h1 << 9;
  localparam logic [20:0] B_RW   = 21'h1 << 8;
  localparam logic [20:0] B_MR   = 21'h1 << 7;
  localparam logic [20:0] B_MW   = 21'h1 << 6;
  localparam logic [20:0] B_J    = 21'h1 << 5;
  localparam logic [20:0] B_BR   = 21'h1 << 4;
  localparam logic [20:0] M_ALL  = 21'h1FFFFF;
  localparam logic [20:0] M_NOALU = 21'h1FF7F0;  // ignores ALUSrc and ALUop

  function automatic logic [20:0] st(input logic [2:0] s);
    return {s, 18'd0};
  endfunction

  task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end else begin
      $display("ok   %s: %06h", tag, got);
    end
  endtask

  // Compare the current cycle (inputs already applied), then advance one clock.
  task automatic cyc(input string tag, input logic [20:0] exp, input logic [20:0] mask);
    #1;
    check_val(tag, vec & mask, exp & mask);
    @(posedge clk);
    #1;
  endtask

  localparam logic [20:0] E_FETCH = {3'd0, 18'd0} | B_PCW | B_IRW;
  localparam logic [20:0] E_DEC   = {3'd1, 18'd0};
  localparam logic [20:0] E_ILL   = {3'd7, 18'd0} | B_TRAP;

  initial begin
    reset = 1'b1; instr = 32'd0; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("reset_held", vec, 21'd0);
    end
    reset = 1'b0;

    // add $3,$1,$2
    instr = 32'h00221820;
    cyc("add_fetch", E_FETCH, M_ALL);
    cyc("add_decode", E_DEC, M_ALL);
    cyc("add_exec", st(2) | B_SRC | 21'h2, M_ALL);
    cyc("add_wb", st(4) | B_RW | B_A2R | B_DONE, M_NOALU);

    // lw with two wait cycles
    instr = 32'h8C220004; mem_ready = 1'b0;
    cyc("lw_fetch", E_FETCH, M_ALL);
    cyc("lw_decode", E_DEC, M_ALL);
    cyc("lw_exec", st(2) | 21'h2, M_ALL);
    cyc("lw_mem_wait1", st(3) | B_MR | 21'h2, M_ALL);
    cyc("lw_mem_wait2", st(3) | B_MR | 21'h2, M_ALL);
    mem_ready = 1'b1;
    cyc("lw_mem_ready", st(3) | B_MR | 21'h2, M_ALL);
    cyc("lw_wb", st(4) | B_RW | B_RDST | B_A2R | B_M2R | B_DONE, M_NOALU);

    // beq taken, then not taken
    instr = 32'h10220003; zero = 1'b1;
    cyc("beq_t_fetch", E_FETCH, M_ALL);
    cyc("beq_t_decode", E_DEC, M_ALL);
    cyc("beq_t_exec", st(2) | B_BR | B_SRC | B_PCW | B_DONE | 21'h6, M_ALL);
    zero = 1'b0;
    cyc("beq_n_fetch", E_FETCH, M_ALL);
    cyc("beq_n_decode", E_DEC, M_ALL);
    cyc("beq_n_exec", st(2) | B_BR | B_SRC | B_DONE | 21'h6, M_ALL);

    // jal
    instr = 32'h0C000010;
    cyc("jal_fetch", E_FETCH, M_ALL);
    cyc("jal_decode", E_DEC, M_ALL);
    cyc("jal_exec", st(2) | B_J | B_PCW | B_RW | B_LINK | B_DONE, M_NOALU);

    // sw with memory ready immediately
    instr = 32'hAC220008;
    cyc("sw_fetch", E_FETCH, M_ALL);
    cyc("sw_decode", E_DEC, M_ALL);
    cyc("sw_exec", st(2) | 21'h2, M_ALL);
    cyc("sw_mem", st(3) | B_MW | B_DONE | 21'h2, M_ALL);

    // illegal opcode 0x3F, held, then reset out of it
    instr = 32'hFC000000;
    cyc("ill_fetch", E_FETCH, M_ALL);
    cyc("ill_decode", E_DEC, M_ALL);
    cyc("ill_hold1", E_ILL, M_ALL);
    cyc("ill_hold2", E_ILL, M_ALL);
    reset = 1'b1;
    cyc("ill_reset", 21'd0, M_ALL);
    reset = 1'b0;
    instr = 32'h00000000;  // R-type with unsupported funct
    cyc("rfn_fetch", E_FETCH, M_ALL);
    cyc("rfn_decode", E_DEC, M_ALL);
    cyc("rfn_illegal", E_ILL, M_ALL);
    reset = 1'b1;
    cyc("rfn_reset", 21'd0, M_ALL);
    reset = 1'b0;

    // reset during a MEM wait
    instr = 32'h8C220004; mem_ready = 1'b0;
    cyc("lwr_fetch", E_FETCH, M_ALL);
    cyc("lwr_decode", E_DEC, M_ALL);
    cyc("lwr_exec", st(2) | 21'h2, M_ALL);
    cyc("lwr_mem", st(3) | B_MR | 21'h2, M_ALL);
    reset = 1'b1;
    cyc("lwr_reset", 21'd0, M_ALL);
    reset = 1'b0; mem_ready = 1'b1;
    instr = 32'h08000004;  // j
    cyc("j_fetch", E_FETCH, M_ALL);
    cyc("j_decode", E_DEC, M_ALL);
    cyc("j_exec", st(2) | B_J | B_PCW | B_DONE, M_NOALU);
    cyc("post_j_fetch", E_FETCH, M_ALL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
